// File: rtl/mc_controller.sv
// Control unit for the multi-cycle ARM datapath: instruction decode, Moore main FSM,
// conditional-execution logic and the NZCV flag register.
module mc_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        IRWrite,
    output logic        AdrSrc,
    output logic [1:0]  RegSrc,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ImmSrc,
    output logic [2:0]  ALUControl
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB,
        S_MEMWRITE, S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BRANCH
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;

    state_t      state_q, state_d, cur_state;
    logic [3:0]  flags_q;
    logic        cond_ex_q;
    logic        cond_ex;

    logic [3:0]  cond;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  rd;
    logic [3:0]  cmd;
    logic        unused_instr;

    assign cond         = Instr[31:28];
    assign op           = Instr[27:26];
    assign funct        = Instr[25:20];
    assign rd           = Instr[15:12];
    assign cmd          = funct[4:1];
    assign unused_instr = ^{Instr[19:16], Instr[11:0]};

    assign ImmSrc    = op;
    assign RegSrc[0] = (op == 2'b10);
    assign RegSrc[1] = (op == 2'b01);

    // While reset is held the selects must already show FETCH values, so decode from
    // the post-reset state rather than the stale one.
    assign cur_state = reset ? S_FETCH : state_q;

    logic next_pc, branch, reg_w, mem_w, alu_op;

    // NOTE: every signal assigned in an always_comb gets a default first; a missing
    // assignment on any path would otherwise infer a latch.
    always_comb begin
        next_pc   = 1'b0;
        branch    = 1'b0;
        reg_w     = 1'b0;
        mem_w     = 1'b0;
        alu_op    = 1'b0;
        IRWrite   = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'd0;
        ResultSrc = 2'd0;
        case (cur_state)
            S_FETCH: begin
                IRWrite   = ~reset;
                next_pc   = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'd2;
                ResultSrc = 2'd2;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'd2;
                ResultSrc = 2'd2;
            end
            S_MEMADR:   ALUSrcB = 2'd1;
            S_MEMREAD:  AdrSrc  = 1'b1;
            S_MEMWB: begin
                ResultSrc = 2'd1;
                reg_w     = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc = 1'b1;
                mem_w  = 1'b1;
            end
            S_EXECUTER: alu_op = 1'b1;
            S_EXECUTEI: begin
                ALUSrcB = 2'd1;
                alu_op  = 1'b1;
            end
            S_ALUWB:    reg_w = 1'b1;
            S_BRANCH: begin
                ALUSrcB   = 2'd1;
                ResultSrc = 2'd2;
                branch    = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    2'b00:   state_d = funct[5] ? S_EXECUTEI : S_EXECUTER;
                    2'b01:   state_d = S_MEMADR;
                    2'b10:   state_d = S_BRANCH;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = funct[0] ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = S_MEMWB;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            default:    state_d = S_FETCH;
        endcase
    end

    logic       no_write;
    logic [1:0] flag_w;
    logic       arith;
    logic [2:0] alu_cmd;

    // NoWrite is tied to data-processing decode so memory ops never lose their writeback.
    always_comb begin
        alu_cmd  = ALU_ADD;
        no_write = 1'b0;
        arith    = 1'b0;
        case (cmd)
            4'b0100: begin alu_cmd = ALU_ADD; arith = 1'b1; end
            4'b0010: begin alu_cmd = ALU_SUB; arith = 1'b1; end
            4'b0000: alu_cmd = ALU_AND;
            4'b1100: alu_cmd = ALU_ORR;
            4'b1010: begin alu_cmd = ALU_SUB; arith = 1'b1; no_write = 1'b1; end
            default: no_write = 1'b1;
        endcase
        if (op != 2'b00) no_write = 1'b0;
        flag_w[1]  = funct[0] & ~(no_write & ~(cmd == 4'b1010));
        flag_w[0]  = funct[0] & arith;
        ALUControl = alu_op ? alu_cmd : ALU_ADD;
    end

    logic n_f, z_f, c_f, v_f;
    assign {n_f, z_f, c_f, v_f} = flags_q;

    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            4'h0: cond_ex = z_f;
            4'h1: cond_ex = ~z_f;
            4'h2: cond_ex = c_f;
            4'h3: cond_ex = ~c_f;
            4'h4: cond_ex = n_f;
            4'h5: cond_ex = ~n_f;
            4'h6: cond_ex = v_f;
            4'h7: cond_ex = ~v_f;
            4'h8: cond_ex = c_f & ~z_f;
            4'h9: cond_ex = ~c_f | z_f;
            4'hA: cond_ex = (n_f == v_f);
            4'hB: cond_ex = (n_f != v_f);
            4'hC: cond_ex = ~z_f & (n_f == v_f);
            4'hD: cond_ex = z_f | (n_f != v_f);
            default: cond_ex = 1'b1;
        endcase
    end

    assign PCWrite  = ~reset & (next_pc | (cond_ex_q & (branch | (reg_w & (rd == 4'd15)))));
    assign RegWrite = ~reset & reg_w & cond_ex_q & ~no_write;
    assign MemWrite = ~reset & mem_w & cond_ex_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            flags_q   <= 4'b0000;
            cond_ex_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE)
                cond_ex_q <= cond_ex;
            if (alu_op & cond_ex_q & flag_w[1])
                flags_q[3:2] <= ALUFlags[3:2];
            if (alu_op & cond_ex_q & flag_w[0])
                flags_q[1:0] <= ALUFlags[1:0];
        end
    end

endmodule

// File: tb/tb_mc_controller.sv
// Directed self-checking bench for mc_controller: walks each instruction class
// cycle by cycle and compares control outputs against hand-derived values.
module tb_mc_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA;
    logic [1:0]  RegSrc, ALUSrcB, ResultSrc, ImmSrc;
    logic [2:0]  ALUControl;

    int vectors    = 0;
    int miscompares = 0;

    mc_controller dut (
        .clk        (clk),
        .reset      (reset),
        .Instr      (Instr),
        .ALUFlags   (ALUFlags),
        .PCWrite    (PCWrite),
        .MemWrite   (MemWrite),
        .RegWrite   (RegWrite),
        .IRWrite    (IRWrite),
        .AdrSrc     (AdrSrc),
        .RegSrc     (RegSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Data-processing register forms: {instr, expected ALUControl, expected RegWrite in ALUWB}
    logic [31:0] dp_instr [5] = '{32'hE0011002, 32'hE0411002, 32'hE1811002, 32'hE0811002, 32'hE0211002};
    logic [2:0]  dp_alu   [5] = '{3'b010, 3'b001, 3'b011, 3'b000, 3'b000};
    logic        dp_wr    [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    int mw_count;

    initial begin
        reset    = 1'b1;
        Instr    = 32'hE2921005;
        ALUFlags = 4'b0100;
        step();
        step();
        check("rst_pcwrite", PCWrite, 0);
        check("rst_irwrite", IRWrite, 0);
        check("rst_memwrite", MemWrite, 0);
        check("rst_regwrite", RegWrite, 0);
        check("rst_alusrcb", ALUSrcB, 2);
        check("rst_resultsrc", ResultSrc, 2);

        // ADDS R1,R2,#5 with ALUFlags Z
        reset = 1'b0;
        #1;
        check("adds_f_irwrite", IRWrite, 1);
        check("adds_f_pcwrite", PCWrite, 1);
        check("adds_f_alusrcb", ALUSrcB, 2);
        check("adds_f_resultsrc", ResultSrc, 2);
        check("adds_f_alusrca", ALUSrcA, 1);
        step();
        check("adds_d_irwrite", IRWrite, 0);
        check("adds_d_pcwrite", PCWrite, 0);
        check("adds_d_regwrite", RegWrite, 0);
        check("adds_d_alusrcb", ALUSrcB, 2);
        check("adds_d_regsrc", RegSrc, 0);
        step();
        check("adds_ei_alusrca", ALUSrcA, 0);
        check("adds_ei_alusrcb", ALUSrcB, 1);
        check("adds_ei_aluctl", ALUControl, 0);
        check("adds_ei_regwrite", RegWrite, 0);
        step();
        check("adds_wb_regwrite", RegWrite, 1);
        check("adds_wb_resultsrc", ResultSrc, 0);
        check("adds_wb_pcwrite", PCWrite, 0);
        step();
        check("adds_f2_irwrite", IRWrite, 1);
        check("adds_f2_regwrite", RegWrite, 0);

        // BEQ taken because ADDS set Z
        Instr = 32'h0A000002;
        step();
        check("beq_d_regsrc", RegSrc, 1);
        check("beq_d_immsrc", ImmSrc, 2);
        step();
        check("beq_br_alusrcb", ALUSrcB, 1);
        check("beq_br_resultsrc", ResultSrc, 2);
        check("beq_br_pcwrite", PCWrite, 1);
        step();

        // CMP R1,#0 producing Z and C
        Instr    = 32'hE3510000;
        ALUFlags = 4'b0110;
        step();
        step();
        check("cmp_ei_aluctl", ALUControl, 1);
        step();
        check("cmp_wb_regwrite", RegWrite, 0);
        step();
        ALUFlags = 4'b0000;

        // BNE not taken: branch state entered, PC not written, fetch resumes
        Instr = 32'h1A000003;
        step();
        step();
        check("bne_br_alusrcb", ALUSrcB, 1);
        check("bne_br_pcwrite", PCWrite, 0);
        step();
        check("bne_f_pcwrite", PCWrite, 1);
        check("bne_f_irwrite", IRWrite, 1);

        // BCS taken: C was loaded by CMP
        Instr = 32'h2A000000;
        step();
        step();
        check("bcs_br_pcwrite", PCWrite, 1);
        step();

        // ADD without S must leave Z intact, so BEQ still branches
        Instr = 32'hE2821005;
        step();
        step();
        step();
        check("add_wb_regwrite", RegWrite, 1);
        step();
        Instr = 32'h0A000002;
        step();
        step();
        check("beq2_br_pcwrite", PCWrite, 1);
        step();

        // Register-form data processing, including an unsupported cmd (EOR)
        for (int i = 0; i < 5; i++) begin
            Instr = dp_instr[i];
            step();
            step();
            check($sformatf("dp%0d_er_alusrcb", i), ALUSrcB, 0);
            check($sformatf("dp%0d_er_aluctl", i), ALUControl, dp_alu[i]);
            step();
            check($sformatf("dp%0d_wb_regwrite", i), RegWrite, dp_wr[i]);
            check($sformatf("dp%0d_wb_aluctl", i), ALUControl, 0);
            step();
        end

        // LDR R2,[R1,#4]
        Instr = 32'hE5912004;
        step();
        check("ldr_d_regsrc", RegSrc, 2);
        check("ldr_d_immsrc", ImmSrc, 1);
        step();
        check("ldr_ma_alusrca", ALUSrcA, 0);
        check("ldr_ma_alusrcb", ALUSrcB, 1);
        check("ldr_ma_aluctl", ALUControl, 0);
        step();
        check("ldr_mr_adrsrc", AdrSrc, 1);
        check("ldr_mr_resultsrc", ResultSrc, 0);
        check("ldr_mr_regwrite", RegWrite, 0);
        step();
        check("ldr_wb_resultsrc", ResultSrc, 1);
        check("ldr_wb_regwrite", RegWrite, 1);
        check("ldr_wb_pcwrite", PCWrite, 0);
        step();
        check("ldr_f_irwrite", IRWrite, 1);

        // STR R2,[R1,#4]: exactly one MemWrite cycle over four
        Instr    = 32'hE5812004;
        mw_count = 0;
        for (int i = 0; i < 4; i++) begin
            mw_count += int'(MemWrite);
            if (i == 3) check("str_mw_adrsrc", AdrSrc, 1);
            step();
        end
        check("str_memwrite_cycles", mw_count, 1);
        check("str_f_irwrite", IRWrite, 1);

        // ADD PC,PC,#8: PC written in FETCH and ALUWB
        Instr = 32'hE28FF008;
        check("movpc_f_pcwrite", PCWrite, 1);
        step();
        step();
        step();
        check("movpc_wb_pcwrite", PCWrite, 1);
        check("movpc_wb_regwrite", RegWrite, 1);
        step();

        // Op=11 behaves as a two-cycle NOP
        Instr = 32'hEC000000;
        step();
        check("op11_d_regwrite", RegWrite, 0);
        check("op11_d_memwrite", MemWrite, 0);
        check("op11_d_pcwrite", PCWrite, 0);
        step();
        check("op11_f_irwrite", IRWrite, 1);

        // Reset raised in MEMWRITE suppresses the store and returns to FETCH
        Instr = 32'hE5812004;
        step();
        step();
        step();
        check("rstmw_pre_memwrite", MemWrite, 1);
        reset = 1'b1;
        #1;
        check("rstmw_memwrite", MemWrite, 0);
        check("rstmw_adrsrc", AdrSrc, 0);
        step();
        check("rstmw_hold_irwrite", IRWrite, 0);
        check("rstmw_hold_pcwrite", PCWrite, 0);
        reset = 1'b0;
        #1;
        check("rstmw_f_irwrite", IRWrite, 1);

        // Flags were cleared by reset, so BEQ is not taken
        Instr = 32'h0A000002;
        step();
        step();
        check("beq3_br_pcwrite", PCWrite, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
